// File: rtl/imm_enc_pkg.sv
// Shared widths, FSM state encoding and operand packing for the rotated-immediate encoder.
package imm_enc_pkg;

    localparam int ROT_W = 4;
    localparam int IMM_W = 8;
    localparam int SO_W  = 12;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEARCH     = 2'd1,
        SEARCH_INV = 2'd2,
        DONE       = 2'd3
    } state_e;

    function automatic logic [SO_W-1:0] pack_so(input logic [ROT_W-1:0] rot,
                                                input logic [IMM_W-1:0] imm8);
        return {rot, imm8};
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle between a client and the immediate encoder.
interface imm_encoder_if;
    import imm_enc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       value;
    logic              out_valid;
    logic              out_ready;
    logic [SO_W-1:0]   shift_operand;
    logic              found;
    logic              inverted;

    modport master (
        output in_valid, value, out_ready,
        input  in_ready, out_valid, shift_operand, found, inverted
    );

    modport slave (
        input  in_valid, value, out_ready,
        output in_ready, out_valid, shift_operand, found, inverted
    );

endinterface

// File: rtl/imm_encoder_rot_match.sv
// Combinational test: does ROL32(word, rot) fit in the low byte? Module name imm_rot_match.
module imm_rot_match
    import imm_enc_pkg::*;
(
    input  logic [31:0]      word_i,
    input  logic [ROT_W-1:0] rot_i,
    output logic             match_o,
    output logic [IMM_W-1:0] imm8_o
);

    logic [31:0] cand;

    // Shift by 32 when rot is 0 yields zero, so the rotate degenerates cleanly.
    assign cand    = (word_i << rot_i) | (word_i >> (6'd32 - {2'b00, rot_i}));
    assign match_o = (cand[31:IMM_W] == '0);
    assign imm8_o  = cand[IMM_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// Iterative 32-bit constant -> {rot, imm8} encoder, one rotation tested per cycle.
// Optional inverted (MVN-class) search enabled by defining IMM_ENC_INV_EN.
module imm_encoder
    import imm_enc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    imm_encoder_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ROT_W-1:0]  rot_q, rot_d;
    logic [31:0]       value_q, value_d;
    logic [SO_W-1:0]   so_q, so_d;
    logic              found_q, found_d;
    logic              inv_q, inv_d;
    logic              ovld_q, ovld_d;

    logic [31:0]       test_word;
    logic              match;
    logic [IMM_W-1:0]  imm8;

`ifdef IMM_ENC_INV_EN
    assign test_word = (state_q == SEARCH_INV) ? ~value_q : value_q;
`else
    assign test_word = value_q;
`endif

    imm_rot_match u_match (
        .word_i  (test_word),
        .rot_i   (rot_q),
        .match_o (match),
        .imm8_o  (imm8)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rot_q   <= '0;
            value_q <= '0;
            so_q    <= '0;
            found_q <= 1'b0;
            inv_q   <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            so_q    <= so_d;
            found_q <= found_d;
            inv_q   <= inv_d;
            ovld_q  <= ovld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        so_d    = so_q;
        found_d = found_q;
        inv_d   = inv_q;
        ovld_d  = ovld_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    value_d = bus.value;
                    rot_d   = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    so_d    = pack_so(rot_q, imm8);
                    found_d = 1'b1;
                    inv_d   = 1'b0;
                    ovld_d  = 1'b1;
                    state_d = DONE;
                end else if (rot_q == '1) begin
`ifdef IMM_ENC_INV_EN
                    rot_d   = '0;
                    state_d = SEARCH_INV;
`else
                    so_d    = '0;
                    found_d = 1'b0;
                    inv_d   = 1'b0;
                    ovld_d  = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    rot_d = rot_q + 1'b1;
                end
            end
`ifdef IMM_ENC_INV_EN
            SEARCH_INV: begin
                if (match) begin
                    so_d    = pack_so(rot_q, imm8);
                    found_d = 1'b1;
                    inv_d   = 1'b1;
                    ovld_d  = 1'b1;
                    state_d = DONE;
                end else if (rot_q == '1) begin
                    so_d    = '0;
                    found_d = 1'b0;
                    inv_d   = 1'b0;
                    ovld_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rot_d = rot_q + 1'b1;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is the only unregistered output; it must drop while reset is held.
    assign bus.in_ready      = (state_q == IDLE) && rst_n;
    assign bus.out_valid     = ovld_q;
    assign bus.shift_operand = so_q;
    assign bus.found         = found_q;
    assign bus.inverted      = inv_q;

endmodule
